pps_mem_unit: RTL
=================

Name: pps_mem_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle memory stage. Sits between Execute and WriteBack.
- Performs byte, halfword and word loads and stores with lane steering, byte enables and sign/zero extension.
- Talks to a variable-latency data memory through a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Non-memory instructions pass through to WriteBack with one-cycle latency.

Parameters:
ADDR_W, 32, byte-address width
MAX_WAIT, 16, cycles in WAIT without ack before abort; 0 disables the timeout
BIG_ENDIAN, 0, 0 = lane is addr[1:0]; 1 = lane is 3-addr[1:0] (half: lane pair flipped likewise)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ex_valid  in  1  EX holds a valid instruction
ex_memop  in  1  instruction accesses memory
ex_memwr  in  1  1 = store, 0 = load
ex_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
ex_sign  in  1  sign-extend load result
ex_addr  in  ADDR_W  effective byte address
ex_stdata  in  32  store data, right-justified
ex_alu  in  32  ALU result for non-memory ops
ex_rd  in  5  destination register
ex_regwrite  in  1  instruction writes rd
stall  out  1  hold EX/ID/IF this cycle (combinational)
mem_req  out  1  access request (registered)
mem_we  out  1  write access
mem_addr  out  ADDR_W  word-aligned address, [1:0] = 00
mem_wdata  out  32  lane-replicated store data
mem_bwe  out  4  byte write enables; 0000 on loads
mem_rdata  in  32  read data, valid when mem_ack = 1
mem_ack  in  1  access complete
wb_valid  out  1  WB payload valid
wb_rd  out  5  destination register
wb_regwrite  out  1  write enable to register file
wb_data  out  32  write data
misalign  out  1  one-cycle pulse on a misaligned access
timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset (async, any time, including mid-access): state = IDLE; all outputs 0; the outstanding access is abandoned; mem_req drops immediately.
- States: IDLE, WAIT.
- IDLE, non-memory op (ex_valid & !ex_memop): next edge sets wb_valid = 1, wb_data = ex_alu, wb_rd/wb_regwrite copied; stall = 0.
- IDLE, !ex_valid: wb_valid = 0 next edge.
- IDLE, aligned mem op: stall = 1 this cycle. At the edge, latch size/sign/lane/rd/regwrite; set mem_req, mem_we, mem_addr, mem_wdata, mem_bwe; wb_valid = 0; go to WAIT.
- Misaligned = (half & addr[0]) | (word & addr[1:0] != 0). No request is issued and stall = 0. Next edge: misalign = 1, wb_valid = 1, wb_regwrite = 0.
- WAIT: stall = !mem_ack. mem_req and all memory outputs are held stable until the ack edge.
- On mem_ack at the edge: mem_req = 0; wb_valid = 1; go to IDLE.
  - Load: wb_data = extracted lane extended per the latched ex_sign, wb_regwrite = latched value.
  - Store: wb_regwrite = 0.
  - The EX instruction presented in that same cycle is the next instruction and is not sampled; IDLE evaluates it on the following cycle, so back-to-back memory ops cost one bubble each.
- Latency: capture at C0, mem_req high in C1, ack in Ck (k ≥ 1), wb_valid in Ck+1. Zero-wait memory (ack in C1) gives exactly one stall cycle.
- Store lanes (little-endian):
  - byte: mem_bwe = 0001 << addr[1:0], wdata = {4{st[7:0]}}
  - half: mem_bwe = 0011 << addr[1:0], wdata = {2{st[15:0]}}
  - word: mem_bwe = 1111, wdata = st
- Timeout: counter cleared on entry to WAIT and incremented each WAIT cycle without ack. When it reaches MAX_WAIT (MAX_WAIT > 0):
  - mem_req = 0, timeout_err = 1
  - wb_valid = 1 with wb_regwrite = 0
  - return to IDLE; stall = 0 in that cycle
- mem_ack while not in WAIT is ignored. ack coincident with the timeout cycle counts as a completion, not a timeout.

Test Plan:
1. Zero-wait load byte: addr 0x1003, rdata 0x80FF_1234, sign = 1 → stall high one cycle; mem_addr 0x1000, bwe 0000; wb_data 0xFFFF_FF80, wb_regwrite 1.
2. Store half: addr 0x2002, st 0x0000_BEEF, ack after 3 cycles → bwe 1100, wdata 0xBEEF_BEEF, mem_req held 3 cycles, stall low in the ack cycle, wb_regwrite 0.
3. Load word at 0x0006 → no mem_req, misalign pulse 1 cycle, wb_valid 1 with wb_regwrite 0, stall 0.
4. MAX_WAIT = 4, ack never arrives → mem_req drops after 4 WAIT cycles, timeout_err stays 1, stall released, next ALU op (ex_alu 0x55) reaches wb_data 0x55.
5. BIG_ENDIAN = 1, load half unsigned at 0x0000, rdata 0x1234_5678 → wb_data 0x0000_1234.
6. rst asserted in WAIT mid-access → mem_req, stall, wb_valid go 0 immediately; after release an ALU op passes with 1-cycle latency.

Source files
------------

// File: rtl/pps_mem_unit.sv
// pps_mem_unit: multi-cycle memory stage between Execute and WriteBack.
// Performs byte/half/word loads and stores with lane steering, byte enables
// and sign/zero extension. Talks to a variable-latency data memory through a
// req/ack handshake and stalls the upstream pipeline while an access is
// outstanding. Non-memory instructions pass to WriteBack with one-cycle latency.
//
// Ports:
//   clk, rst                        clock (rising edge), async active-high reset
//   ex_valid/ex_memop/ex_memwr      EX instruction qualifiers (valid, memory op, store)
//   ex_size/ex_sign                 access size (00 b, 01 h, 1x w) and load sign-extend
//   ex_addr/ex_stdata/ex_alu        byte address, right-justified store data, ALU result
//   ex_rd/ex_regwrite               destination register and its write enable
//   stall                           combinational hold request to EX/ID/IF
//   mem_req/mem_we/mem_addr         registered memory request, write flag, word address
//   mem_wdata/mem_bwe               lane-replicated store data and byte write enables
//   mem_rdata/mem_ack               read data and access-complete strobe
//   wb_valid/wb_rd/wb_regwrite/wb_data  WriteBack payload
//   misalign                        one-cycle pulse on a misaligned access
//   timeout_err                     sticky: memory failed to ack within MAX_WAIT cycles
//
// States:
//   state  | meaning
//   S_IDLE | accepting EX instructions; ALU ops pass through, mem ops issue
//   S_WAIT | request outstanding; memory outputs held until ack or timeout

module pps_mem_unit #(
  parameter int ADDR_W     = 32,
  parameter int MAX_WAIT   = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memop,
  input  logic              ex_memwr,
  input  logic [1:0]        ex_size,
  input  logic              ex_sign,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_stdata,
  input  logic [31:0]       ex_alu,
  input  logic [4:0]        ex_rd,
  input  logic              ex_regwrite,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_bwe,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_regwrite,
  output logic [31:0]       wb_data,
  output logic              misalign,
  output logic              timeout_err
);

  // Counter only has to reach MAX_WAIT-1 before the timeout fires.
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;

  logic [1:0]         lat_size;
  logic               lat_sign;
  logic [1:0]         lat_lane;
  logic [4:0]         lat_rd;
  logic               lat_regwrite;
  logic               lat_wr;

  logic               is_byte, is_half, is_word;
  logic               ex_mis;
  logic [1:0]         ex_lane;
  logic               ex_mem;
  logic               timeout_hit;
  logic               start_acc, complete_acc, timeout_acc;
  logic [3:0]         st_bwe;
  logic [31:0]        st_wdata;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_value;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    is_byte = (ex_size == 2'b00);
    is_half = (ex_size == 2'b01);
    is_word = ex_size[1];
    ex_mis  = (is_half & ex_addr[0]) | (is_word & (ex_addr[1:0] != 2'b00));
    ex_mem  = ex_valid & ex_memop;

    // Physical lane: big-endian flips the byte index, and for halves flips
    // which pair is addressed.
    ex_lane = ex_addr[1:0];
    if (BIG_ENDIAN) begin
      if (is_byte)      ex_lane = ~ex_addr[1:0];
      else if (is_half) ex_lane = ex_addr[1:0] ^ 2'b10;
      else              ex_lane = 2'b00;
    end

    st_bwe   = 4'b1111;
    st_wdata = ex_stdata;
    if (is_byte) begin
      st_bwe   = 4'b0001 << ex_lane;
      st_wdata = {4{ex_stdata[7:0]}};
    end else if (is_half) begin
      st_bwe   = 4'b0011 << ex_lane;
      st_wdata = {2{ex_stdata[15:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the latched lane
  // ---------------------------------------------------------------------------
  always_comb begin
    case (lat_lane)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    if (lat_size == 2'b00)
      ld_value = {{24{lat_sign & ld_byte[7]}}, ld_byte};
    else if (lat_size == 2'b01)
      ld_value = {{16{lat_sign & ld_half[15]}}, ld_half};
    else
      ld_value = mem_rdata;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign timeout_hit = (MAX_WAIT > 0) && !mem_ack &&
                       (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    start_acc    = 1'b0;
    complete_acc = 1'b0;
    timeout_acc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ex_mem && !ex_mis) begin
          stall     = 1'b1;
          start_acc = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ack wins over a coincident timeout.
        if (mem_ack) begin
          complete_acc = 1'b1;
          state_nxt    = S_IDLE;
        end else if (timeout_hit) begin
          timeout_acc = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Stall must read 0 while reset is held, even with a mem op in EX.
    if (rst) stall = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      lat_size     <= 2'b00;
      lat_sign     <= 1'b0;
      lat_lane     <= 2'b00;
      lat_rd       <= 5'd0;
      lat_regwrite <= 1'b0;
      lat_wr       <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      mem_bwe      <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_regwrite  <= 1'b0;
      wb_data      <= 32'd0;
      misalign     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid && !ex_memop) begin
            wb_valid    <= 1'b1;
            wb_data     <= ex_alu;
            wb_rd       <= ex_rd;
            wb_regwrite <= ex_regwrite;
          end else if (ex_mem && ex_mis) begin
            misalign    <= 1'b1;
            wb_valid    <= 1'b1;
            wb_rd       <= ex_rd;
            wb_regwrite <= 1'b0;
            wb_data     <= 32'd0;
          end else if (start_acc) begin
            wait_cnt     <= '0;
            lat_size     <= ex_size;
            lat_sign     <= ex_sign;
            lat_lane     <= ex_lane;
            lat_rd       <= ex_rd;
            lat_regwrite <= ex_regwrite;
            lat_wr       <= ex_memwr;
            mem_req      <= 1'b1;
            mem_we       <= ex_memwr;
            mem_addr     <= {ex_addr[ADDR_W-1:2], 2'b00};
            mem_wdata    <= st_wdata;
            mem_bwe      <= ex_memwr ? st_bwe : 4'b0000;
          end
        end
        S_WAIT: begin
          if (complete_acc) begin
            mem_req     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_rd       <= lat_rd;
            wb_regwrite <= lat_regwrite & ~lat_wr;
            wb_data     <= lat_wr ? 32'd0 : ld_value;
          end else if (timeout_acc) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            wb_valid    <= 1'b1;
            wb_rd       <= lat_rd;
            wb_regwrite <= 1'b0;
            wb_data     <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
